// File: rtl/alu_regfile_seq_if.sv
// Command/result channel of the register-file datapath: the requester issues one
// operation per handshake and sees the registered result, flags and completion pulse.
`timescale 1ns/1ps
interface alu_regfile_seq_if #(
  parameter int WIDTH = 8,
  parameter int SELW  = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SELW-1:0]  SELA;
  logic [SELW-1:0]  SELB;
  logic [SELW-1:0]  SELD;
  logic [3:0]       OPR;
  logic [WIDTH-1:0] Input;
  logic [WIDTH-1:0] Output;
  logic             carry;
  logic             zero;
  logic             Done;

  modport master (
    output cmd_valid, SELA, SELB, SELD, OPR, Input,
    input  cmd_ready, Output, carry, zero, Done
  );

  modport slave (
    input  cmd_valid, SELA, SELB, SELD, OPR, Input,
    output cmd_ready, Output, carry, zero, Done
  );
endinterface

// File: rtl/alu_regfile_seq.sv
// Register bank + operand muxes + flagged ALU, sequenced IDLE -> EXEC -> WRITE so that
// one command completes every three clocks. Select 0 means the Input bus / no writeback.
`timescale 1ns/1ps
module alu_regfile_seq #(
  parameter int WIDTH = 8,
  parameter int SELW  = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  alu_regfile_seq_if.slave bus,
  input  logic [SELW-1:0]  dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int NREG = 2**SELW;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] op_a, op_b;
  logic [SELW-1:0]  seld_q;
  logic [3:0]       opr_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q, zero_q, done_q;

  logic [WIDTH-1:0] mux_a, mux_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   wide;

  // Entry 0 of the bank is never written, so select 0 is steered to the Input bus here.
  always_comb begin
    mux_a = (bus.SELA == '0) ? bus.Input : regs[bus.SELA];
    mux_b = (bus.SELB == '0) ? bus.Input : regs[bus.SELB];
  end

  always_comb begin
    wide      = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opr_q)
      4'd0:  begin wide = {1'b0, op_a} + {1'b0, op_b};        alu_res = wide[WIDTH-1:0]; alu_carry = wide[WIDTH]; end
      4'd1:  begin wide = {1'b0, op_a} - {1'b0, op_b};        alu_res = wide[WIDTH-1:0]; alu_carry = wide[WIDTH]; end
      4'd2:  alu_res = op_a & op_b;
      4'd3:  alu_res = op_a | op_b;
      4'd4:  alu_res = op_a ^ op_b;
      4'd5:  alu_res = ~(op_a | op_b);
      4'd6:  alu_res = ~op_a;
      4'd7:  alu_res = op_a;
      4'd8:  alu_res = op_b;
      4'd9:  begin alu_res = {op_a[WIDTH-2:0], 1'b0}; alu_carry = op_a[WIDTH-1]; end
      4'd10: begin alu_res = {1'b0, op_a[WIDTH-1:1]}; alu_carry = op_a[0]; end
      4'd11: begin wide = {1'b0, op_a} + (WIDTH+1)'(1);       alu_res = wide[WIDTH-1:0]; alu_carry = wide[WIDTH]; end
      4'd12: begin wide = {1'b0, op_a} - (WIDTH+1)'(1);       alu_res = wide[WIDTH-1:0]; alu_carry = wide[WIDTH]; end
      4'd13: alu_res = '0 - op_a;
      4'd14: alu_res = WIDTH'(op_a < op_b);
      4'd15: alu_res = WIDTH'(op_a == op_b);
    endcase
  end

  // Clear is applied after the sequencer so it overrides a same-edge writeback.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      op_a    <= '0;
      op_b    <= '0;
      seld_q  <= '0;
      opr_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_a   <= mux_a;
            op_b   <= mux_b;
            seld_q <= bus.SELD;
            opr_q  <= bus.OPR;
            state  <= EXEC;
          end
        end
        EXEC: begin
          out_q   <= alu_res;
          carry_q <= alu_carry;
          zero_q  <= (alu_res == '0);
          state   <= WRITE;
        end
        WRITE: begin
          if (seld_q != '0) regs[seld_q] <= out_q;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (Clear) begin
        for (int i = 1; i < NREG; i++) regs[i] <= '0;
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.Output    = out_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.Done      = done_q;
  assign dbg_data      = (dbg_sel == '0) ? bus.Input : regs[dbg_sel];

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: directed and random commands on an 8-bit instance, scoreboarded
// against an arithmetic reference model, plus a 16-bit/16-register instance for wrap and abort.
`timescale 1ns/1ps
module tb_alu_regfile_seq;

  logic Clock = 1'b0;
  always #10 Clock = ~Clock;

  logic       Reset, Clear;
  logic [2:0] dbg_sel;
  logic [7:0] dbg_data;
  alu_regfile_seq_if bus();

  alu_regfile_seq dut (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .bus(bus),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  logic        Reset2, Clear2;
  logic [3:0]  dbg_sel2;
  logic [15:0] dbg_data2;
  alu_regfile_seq_if #(.WIDTH(16), .SELW(4)) bus2();

  alu_regfile_seq #(.WIDTH(16), .SELW(4)) dut2 (
    .Clock(Clock), .Reset(Reset2), .Clear(Clear2), .bus(bus2),
    .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
  );

  typedef struct {
    logic [7:0]      out;
    bit              c;
    bit              z;
    logic [7:0][7:0] regs;
  } exp_t;

  exp_t            sb[$];
  logic [7:0][7:0] mregs;
  int              checks = 0;
  int              errors = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference ALU expressed as modular integer arithmetic on a w-bit word.
  function automatic void ref_alu(input int w, input int opr, input longint a, input longint b,
                                  output longint res, output bit c);
    longint m;
    m = longint'(1) << w;
    c = 1'b0;
    res = 0;
    case (opr)
      0:  begin res = a + b; c = (res >= m); end
      1:  begin res = a - b + m; c = (a < b); end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = (m - 1) - (a | b);
      6:  res = (m - 1) - a;
      7:  res = a;
      8:  res = b;
      9:  begin res = a * 2; c = (a >= m / 2); end
      10: begin res = a / 2; c = (a % 2 == 1); end
      11: begin res = a + 1; c = (a == m - 1); end
      12: begin res = a - 1 + m; c = (a == 0); end
      13: res = m - a;
      14: res = (a < b) ? 1 : 0;
      15: res = (a == b) ? 1 : 0;
      default: res = 0;
    endcase
    res = res % m;
  endfunction

  function automatic void pushExpected(input int sela, input int selb, input int seld,
                                       input int opr, input longint inp, input bit clr);
    longint a, b, res;
    bit     c;
    exp_t   e;
    a = (sela == 0) ? inp : longint'(mregs[sela]);
    b = (selb == 0) ? inp : longint'(mregs[selb]);
    ref_alu(8, opr, a, b, res, c);
    if (seld != 0) mregs[seld] = 8'(res);
    if (clr) mregs = '0;
    e.out  = 8'(res);
    e.c    = c;
    e.z    = (res == 0);
    e.regs = mregs;
    sb.push_back(e);
  endfunction

  task automatic driveCmd(input int sela, input int selb, input int seld, input int opr,
                          input longint inp, input bit clr);
    int budget = 0;
    @(negedge Clock);
    bus.cmd_valid = 1'b1;
    bus.SELA      = 3'(sela);
    bus.SELB      = 3'(selb);
    bus.SELD      = 3'(seld);
    bus.OPR       = 4'(opr);
    bus.Input     = 8'(inp);
    while (!bus.cmd_ready && budget < 20) begin
      @(negedge Clock);
      budget++;
    end
    if (budget >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: got cmd_ready=0, expected 1 within 20 cycles");
    end
    @(posedge Clock);
    #1 bus.cmd_valid = 1'b0;
    if (clr) begin
      @(negedge Clock);
      @(negedge Clock);
      Clear = 1'b1;
      @(posedge Clock);
      #1 Clear = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int sela, input int selb, input int seld, input int opr,
                               input longint inp, input bit clr);
    pushExpected(sela, selb, seld, opr, inp, clr);
    driveCmd(sela, selb, seld, opr, inp, clr);
  endtask

  task automatic waitIdle();
    int budget = 0;
    @(negedge Clock);
    while (!bus.cmd_ready && budget < 20) begin
      @(negedge Clock);
      budget++;
    end
  endtask

  task automatic issue2(input int sela, input int selb, input int seld, input int opr,
                        input longint inp);
    int budget = 0;
    @(negedge Clock);
    bus2.cmd_valid = 1'b1;
    bus2.SELA      = 4'(sela);
    bus2.SELB      = 4'(selb);
    bus2.SELD      = 4'(seld);
    bus2.OPR       = 4'(opr);
    bus2.Input     = 16'(inp);
    while (!bus2.cmd_ready && budget < 20) begin
      @(negedge Clock);
      budget++;
    end
    @(posedge Clock);
    #1 bus2.cmd_valid = 1'b0;
  endtask

  task automatic waitDone2(output bit seen);
    seen = 1'b0;
    repeat (8) begin
      @(negedge Clock);
      if (bus2.Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: every Done pulse retires the oldest expectation and sweeps the register file.
  initial begin : monitor
    exp_t e;
    dbg_sel = '0;
    forever begin
      @(negedge Clock);
      if (bus.Done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got Done=1, expected no pending command");
        end else begin
          e = sb.pop_front();
          checkOutput("Output", bus.Output, e.out);
          checkOutput("carry", bus.carry, e.c);
          checkOutput("zero", bus.zero, e.z);
          for (int r = 1; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1 checkOutput($sformatf("R%0d", r), dbg_data, e.regs[r]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int     accepted;
    bit     seen;
    longint res;
    bit     c;
    logic [7:0] inp;

    Reset = 1'b1; Clear = 1'b0;
    bus.cmd_valid = 1'b0; bus.SELA = '0; bus.SELB = '0; bus.SELD = '0; bus.OPR = '0; bus.Input = '0;
    Reset2 = 1'b1; Clear2 = 1'b0; dbg_sel2 = '0;
    bus2.cmd_valid = 1'b0; bus2.SELA = '0; bus2.SELB = '0; bus2.SELD = '0; bus2.OPR = '0; bus2.Input = '0;
    mregs = '0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0; Reset2 = 1'b0;
    @(negedge Clock);
    checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
    checkOutput("reset_Output", bus.Output, 0);
    checkOutput("reset_Done", bus.Done, 0);
    checkOutput("reset_carry", bus.carry, 0);
    checkOutput("reset_zero", bus.zero, 0);

    applyStimulus(0, 0, 1, 0, 125, 0);
    applyStimulus(1, 0, 2, 1, 251, 0);

    applyStimulus(0, 0, 1, 7, 144, 0);
    applyStimulus(0, 0, 2, 7, 112, 0);
    applyStimulus(1, 2, 3, 0, 0, 0);
    applyStimulus(1, 1, 6, 15, 0, 0);
    applyStimulus(0, 0, 7, 9, 'h81, 0);

    // Valid held for six cycles: only the idle cycles 0 and 3 may accept.
    waitIdle();
    accepted = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc != 0) @(negedge Clock);
      inp = 8'($urandom);
      bus.cmd_valid = 1'b1; bus.SELA = 3'd0; bus.SELB = 3'd1; bus.SELD = 3'd4; bus.OPR = 4'd0;
      bus.Input = inp;
      checkOutput($sformatf("hold_ready_c%0d", cyc), bus.cmd_ready, (cyc % 3 == 0) ? 1 : 0);
      if (bus.cmd_ready) begin
        accepted++;
        pushExpected(0, 1, 4, 0, inp, 0);
      end
    end
    @(negedge Clock);
    bus.cmd_valid = 1'b0;
    checkOutput("hold_accepted", accepted, 2);

    applyStimulus(0, 0, 1, 7, 'h0F, 0);
    applyStimulus(1, 0, 0, 6, 'h55, 0);

    for (int n = 0; n < 30; n++)
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 15), $urandom_range(0, 255), 0);

    applyStimulus(0, 0, 5, 7, 'h33, 1);

    // Reset while the command sits in EXEC: nothing may complete.
    waitIdle();
    driveCmd(0, 0, 6, 0, 'h40, 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    mregs = '0;
    checkOutput("abort_Output", bus.Output, 0);
    checkOutput("abort_cmd_ready", bus.cmd_ready, 1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge Clock);
      if (bus.Done === 1'b1) seen = 1'b1;
    end
    checkOutput("abort_no_done", seen, 0);
    applyStimulus(0, 0, 2, 8, 'hA7, 0);

    repeat (20) begin
      if (sb.size() != 0) @(negedge Clock);
    end
    checkOutput("scoreboard_drain", sb.size(), 0);

    // Wide instance: abort, then 0xFFFF + 1 wrapping into R15.
    issue2(0, 0, 15, 11, 'hFFFF);
    @(negedge Clock);
    Reset2 = 1'b1;
    @(posedge Clock);
    #1 Reset2 = 1'b0;
    waitDone2(seen);
    checkOutput("w16_abort_no_done", seen, 0);
    checkOutput("w16_abort_Output", bus2.Output, 0);
    issue2(0, 0, 15, 7, 'h1234);
    waitDone2(seen);
    checkOutput("w16_load_done", seen, 1);
    dbg_sel2 = 4'd15;
    #1 checkOutput("w16_R15_load", dbg_data2, 'h1234);
    ref_alu(16, 11, 'hFFFF, 0, res, c);
    issue2(0, 0, 15, 11, 'hFFFF);
    waitDone2(seen);
    checkOutput("w16_inc_done", seen, 1);
    checkOutput("w16_inc_Output", bus2.Output, res);
    checkOutput("w16_inc_carry", bus2.carry, c);
    checkOutput("w16_inc_zero", bus2.zero, (res == 0) ? 1 : 0);
    #1 checkOutput("w16_R15_inc", dbg_data2, res);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
